usb_cdc_fifo_apb: RTL

//  APB slave for the USB CDC path with parametrised, internal TX/RX FIFOs and valid/ready byte streams to the CDC core.

---
 rtl/usb_cdc_fifo_apb_if.sv | 30 +++
 rtl/usb_cdc_fifo_apb.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_cdc_fifo_apb_if.sv
// ---------------------------------------------------------------------------
// usb_cdc_fifo_apb_if
// APB3 bus bundle used between the SoC interconnect and usb_cdc_fifo_apb.
//   PADDR   : 32-bit address, master -> slave
//   PWRITE  : write strobe qualifier, master -> slave
//   PSEL    : slave select, master -> slave
//   PENABLE : access phase marker, master -> slave
//   PWDATA  : 32-bit write data, master -> slave
//   PRDATA  : 32-bit read data, slave -> master
//   PREADY  : transfer complete, slave -> master
// ---------------------------------------------------------------------------
interface usb_cdc_fifo_apb_if;
  logic [31:0] PADDR;
  logic        PWRITE;
  logic        PSEL;
  logic        PENABLE;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;

  modport master (
    output PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    input  PRDATA, PREADY
  );

  modport slave (
    input  PADDR, PWRITE, PSEL, PENABLE, PWDATA,
    output PRDATA, PREADY
  );
endinterface

// File: rtl/usb_cdc_fifo_apb.sv
// ---------------------------------------------------------------------------
// usb_cdc_fifo_apb
// APB slave fronting the USB CDC endpoint: a TX FIFO fed by APB writes and
// drained by a valid/ready byte stream, an RX FIFO fed by a stream and
// drained by APB reads, plus level/threshold/timeout/error interrupts.
//
// Ports
//   PCLK, PRESETn        : clock (rising edge) and synchronous active-low reset
//   apb (slave modport)  : APB3 bus, PRDATA combinational, PREADY tied high
//   irq                  : |(RIS & IM)
//   en_o                 : CONTROL.EN to the CDC core
//   tx_tdata_o/tvalid_o  : TX FIFO head and valid (EN & not empty)
//   tx_tready_i          : core takes head when valid & ready
//   rx_tdata_i/tvalid_i  : bytes offered by the core
//   rx_tready_o          : EN & not full
//
// Register map (byte offsets, PADDR[15:0])
//   0x00 TXDATA W   0x04 RXDATA R   0x08 TXLEVEL R   0x0C RXLEVEL R
//   0x10 TXFIFOT RW 0x14 RXFIFOT RW 0x18 CONTROL RW  0x1C RXTO RW
//   0xFF00 IM RW    0xFF04 MIS R    0xFF08 RIS R     0xFF0C ICR W
// ---------------------------------------------------------------------------
module usb_cdc_fifo_apb #(
  parameter int DW   = 8,
  parameter int AW   = 4,
  parameter int TO_W = 16
) (
  input  logic                 PCLK,
  input  logic                 PRESETn,
  usb_cdc_fifo_apb_if.slave    apb,
  output logic                 irq,
  output logic                 en_o,
  output logic [DW-1:0]        tx_tdata_o,
  output logic                 tx_tvalid_o,
  input  logic                 tx_tready_i,
  input  logic [DW-1:0]        rx_tdata_i,
  input  logic                 rx_tvalid_i,
  output logic                 rx_tready_o
);

  localparam int          DEPTH    = 1 << AW;
  localparam int          NI       = 9;
  localparam logic [AW:0] LVL_FULL = (AW+1)'(DEPTH);

  localparam logic [15:0] A_TXDATA  = 16'h0000;
  localparam logic [15:0] A_RXDATA  = 16'h0004;
  localparam logic [15:0] A_TXLEVEL = 16'h0008;
  localparam logic [15:0] A_RXLEVEL = 16'h000C;
  localparam logic [15:0] A_TXFIFOT = 16'h0010;
  localparam logic [15:0] A_RXFIFOT = 16'h0014;
  localparam logic [15:0] A_CONTROL = 16'h0018;
  localparam logic [15:0] A_RXTO    = 16'h001C;
  localparam logic [15:0] A_IM      = 16'hFF00;
  localparam logic [15:0] A_MIS     = 16'hFF04;
  localparam logic [15:0] A_RIS     = 16'hFF08;
  localparam logic [15:0] A_ICR     = 16'hFF0C;

  // ---------------- APB decode ----------------
  logic [15:0] addr;
  logic        access, wr, rd;

  assign addr   = apb.PADDR[15:0];
  assign access = apb.PSEL & apb.PENABLE;
  assign wr     = access & apb.PWRITE;
  assign rd     = access & ~apb.PWRITE;

  // upper address bits and unused write-data bits are intentionally ignored
  logic unused_bits;
  assign unused_bits = ^{apb.PADDR[31:16], apb.PWDATA};

  // ---------------- control / config registers ----------------
  logic            en_reg;
  logic [AW:0]     txfifot_reg, rxfifot_reg;
  logic [TO_W-1:0] rxto_reg;
  logic [NI-1:0]   im_reg;
  logic [NI-1:0]   icr_reg;   // one-cycle clear pulse, applied on the next edge
  logic [NI-1:0]   ris_reg, ris_next, ris_src;

  // ---------------- FIFO state ----------------
  logic [DW-1:0] tx_mem [DEPTH];
  logic [DW-1:0] rx_mem [DEPTH];

  logic [AW-1:0] tx_wptr_reg, tx_wptr_next, tx_rptr_reg, tx_rptr_next;
  logic [AW-1:0] rx_wptr_reg, rx_wptr_next, rx_rptr_reg, rx_rptr_next;
  logic [AW:0]   tx_level_reg, tx_level_next, rx_level_reg, rx_level_next;

  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_flush, rx_flush;
  logic tx_push_req, tx_push, tx_pop, tx_ovf;
  logic rx_rd_req, rx_push, rx_pop, rx_unf;

  assign tx_full  = (tx_level_reg == LVL_FULL);
  assign tx_empty = (tx_level_reg == '0);
  assign rx_full  = (rx_level_reg == LVL_FULL);
  assign rx_empty = (rx_level_reg == '0);

  // flush bits act only as write strobes and are never stored
  assign tx_flush = wr & (addr == A_CONTROL) & apb.PWDATA[1];
  assign rx_flush = wr & (addr == A_CONTROL) & apb.PWDATA[2];

  // TX side: APB pushes, stream pops.  Overflow is judged on the level at the
  // start of the cycle, so a simultaneous stream pop does not rescue the write.
  assign tx_push_req = wr & (addr == A_TXDATA);
  assign tx_push     = tx_push_req & ~tx_full & ~tx_flush;
  assign tx_ovf      = tx_push_req & tx_full;
  assign tx_tvalid_o = en_reg & ~tx_empty;
  assign tx_pop      = tx_tvalid_o & tx_tready_i & ~tx_flush;
  assign tx_tdata_o  = tx_mem[tx_rptr_reg];

  // RX side: stream pushes, APB read pops.
  assign rx_tready_o = en_reg & ~rx_full;
  assign rx_push     = rx_tvalid_i & rx_tready_o & ~rx_flush;
  assign rx_rd_req   = rd & (addr == A_RXDATA);
  assign rx_pop      = rx_rd_req & ~rx_empty & ~rx_flush;
  assign rx_unf      = rx_rd_req & rx_empty;

  assign en_o = en_reg;

  always_ff @(posedge PCLK) begin
    if (tx_push) tx_mem[tx_wptr_reg] <= apb.PWDATA[DW-1:0];
  end

  always_ff @(posedge PCLK) begin
    if (rx_push) rx_mem[rx_wptr_reg] <= rx_tdata_i;
  end

  always_comb begin
    tx_wptr_next  = tx_wptr_reg;
    tx_rptr_next  = tx_rptr_reg;
    tx_level_next = tx_level_reg;
    if (tx_flush) begin
      tx_wptr_next  = '0;
      tx_rptr_next  = '0;
      tx_level_next = '0;
    end else begin
      if (tx_push) tx_wptr_next = tx_wptr_reg + 1'b1;
      if (tx_pop)  tx_rptr_next = tx_rptr_reg + 1'b1;
      case ({tx_push, tx_pop})
        2'b10:   tx_level_next = tx_level_reg + 1'b1;
        2'b01:   tx_level_next = tx_level_reg - 1'b1;
        default: tx_level_next = tx_level_reg;
      endcase
    end
  end

  always_comb begin
    rx_wptr_next  = rx_wptr_reg;
    rx_rptr_next  = rx_rptr_reg;
    rx_level_next = rx_level_reg;
    if (rx_flush) begin
      rx_wptr_next  = '0;
      rx_rptr_next  = '0;
      rx_level_next = '0;
    end else begin
      if (rx_push) rx_wptr_next = rx_wptr_reg + 1'b1;
      if (rx_pop)  rx_rptr_next = rx_rptr_reg + 1'b1;
      case ({rx_push, rx_pop})
        2'b10:   rx_level_next = rx_level_reg + 1'b1;
        2'b01:   rx_level_next = rx_level_reg - 1'b1;
        default: rx_level_next = rx_level_reg;
      endcase
    end
  end

  // ---------------- RX idle timeout ----------------
  logic [TO_W-1:0] to_cnt_reg, to_cnt_next;
  logic            to_clr, to_run, to_fire;

  // Counter stops at RXTO, so the event fires only on the step that reaches it.
  assign to_clr  = rx_push | rx_pop | rx_flush | (rxto_reg == '0);
  assign to_run  = ~to_clr & ~rx_empty & (to_cnt_reg < rxto_reg);
  assign to_fire = to_run & ((to_cnt_reg + 1'b1) == rxto_reg);

  always_comb begin
    to_cnt_next = to_cnt_reg;
    if (to_clr)      to_cnt_next = '0;
    else if (to_run) to_cnt_next = to_cnt_reg + 1'b1;
  end

  // ---------------- interrupts ----------------
  assign ris_src = {rx_unf,
                    tx_ovf,
                    to_fire,
                    tx_full,
                    rx_empty,
                    (rx_level_reg > rxfifot_reg),
                    rx_full,
                    (tx_level_reg < txfifot_reg),
                    tx_empty};

  // a live source wins over a pending clear on the same edge
  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_ris
      assign ris_next[gi] = (ris_reg[gi] & ~icr_reg[gi]) | ris_src[gi];
    end
  endgenerate

  assign irq = |(ris_reg & im_reg);

  // ---------------- sequential state ----------------
  always_ff @(posedge PCLK) begin
    if (!PRESETn) begin
      en_reg       <= 1'b0;
      txfifot_reg  <= '0;
      rxfifot_reg  <= '0;
      rxto_reg     <= '0;
      im_reg       <= '0;
      icr_reg      <= '0;
      ris_reg      <= '0;
      tx_wptr_reg  <= '0;
      tx_rptr_reg  <= '0;
      tx_level_reg <= '0;
      rx_wptr_reg  <= '0;
      rx_rptr_reg  <= '0;
      rx_level_reg <= '0;
      to_cnt_reg   <= '0;
    end else begin
      icr_reg      <= '0;
      ris_reg      <= ris_next;
      tx_wptr_reg  <= tx_wptr_next;
      tx_rptr_reg  <= tx_rptr_next;
      tx_level_reg <= tx_level_next;
      rx_wptr_reg  <= rx_wptr_next;
      rx_rptr_reg  <= rx_rptr_next;
      rx_level_reg <= rx_level_next;
      to_cnt_reg   <= to_cnt_next;
      if (wr) begin
        case (addr)
          A_TXFIFOT: txfifot_reg <= apb.PWDATA[AW:0];
          A_RXFIFOT: rxfifot_reg <= apb.PWDATA[AW:0];
          A_CONTROL: en_reg      <= apb.PWDATA[0];
          A_RXTO:    rxto_reg    <= apb.PWDATA[TO_W-1:0];
          A_IM:      im_reg      <= apb.PWDATA[NI-1:0];
          A_ICR:     icr_reg     <= apb.PWDATA[NI-1:0];
          default:   ;
        endcase
      end
    end
  end

  // ---------------- read mux ----------------
  logic [31:0] rdata;

  always_comb begin
    rdata = 32'hDEADBEEF;
    case (addr)
      A_TXDATA, A_ICR: rdata = '0;
      A_RXDATA: begin
        rdata = '0;
        if (!rx_empty) rdata[DW-1:0] = rx_mem[rx_rptr_reg];
      end
      A_TXLEVEL: begin
        rdata = '0;
        rdata[AW:0] = tx_level_reg;
      end
      A_RXLEVEL: begin
        rdata = '0;
        rdata[AW:0] = rx_level_reg;
      end
      A_TXFIFOT: begin
        rdata = '0;
        rdata[AW:0] = txfifot_reg;
      end
      A_RXFIFOT: begin
        rdata = '0;
        rdata[AW:0] = rxfifot_reg;
      end
      A_CONTROL: begin
        rdata = '0;
        rdata[0] = en_reg;
      end
      A_RXTO: begin
        rdata = '0;
        rdata[TO_W-1:0] = rxto_reg;
      end
      A_IM: begin
        rdata = '0;
        rdata[NI-1:0] = im_reg;
      end
      A_MIS: begin
        rdata = '0;
        rdata[NI-1:0] = ris_reg & im_reg;
      end
      A_RIS: begin
        rdata = '0;
        rdata[NI-1:0] = ris_reg;
      end
      default: rdata = 32'hDEADBEEF;
    endcase
  end

  assign apb.PRDATA = rdata;
  assign apb.PREADY = 1'b1;

endmodule
